// File: rtl/comparator_serial_if.sv
// Bit-pair stream and result bundle for the serial magnitude comparator.
// master drives the bit stream, slave is the comparator.
interface comparator_serial_if;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic greater;
  logic less;
  logic equal;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, done, greater, less, equal
  );

  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, done, greater, less, equal
  );
endinterface

// File: rtl/comparator_serial.sv
// Bit-serial MSB-first magnitude comparator: one (a,b) pair per accepted beat,
// registered greater/less/equal plus a one-cycle done pulse after the last beat.
module comparator_serial #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  comparator_serial_if.slave cmp
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic greater;
    logic less;
    logic equal;
  } result_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          decided;
  logic          dec_gt;
  result_t       res;

  logic accept, last_beat, mismatch;

  assign accept    = (state == RUN) && cmp.bit_valid;
  assign last_beat = accept && (cnt == LAST);
  assign mismatch  = cmp.a_bit ^ cmp.b_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (cmp.start) state_nxt = RUN;
      RUN:     if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmp.busy    = (state != IDLE);
    cmp.done    = (state == DONE);
    cmp.greater = res.greater;
    cmp.less    = res.less;
    cmp.equal   = res.equal;
  end

  // The first differing pair latches the verdict; later pairs only advance cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      res     <= '0;
    end else begin
      if (state == IDLE && cmp.start) begin
        cnt     <= '0;
        decided <= 1'b0;
        dec_gt  <= 1'b0;
        res     <= '0;
      end else if (accept) begin
        cnt <= cnt + ONE;
        if (!decided && mismatch) begin
          decided <= 1'b1;
          dec_gt  <= cmp.a_bit;
        end
        if (last_beat) begin
          if (decided)       res <= '{greater: dec_gt,    less: !dec_gt,    equal: 1'b0};
          else if (mismatch) res <= '{greater: cmp.a_bit, less: !cmp.a_bit, equal: 1'b0};
          else               res <= '{greater: 1'b0,      less: 1'b0,       equal: 1'b1};
        end
      end
    end
  end

  a_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({res.greater, res.less, res.equal}));
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DONE) |=> (state == IDLE));
  a_done_result: assert property (@(posedge clk) disable iff (!rst_n)
    (state == DONE) |-> $onehot({res.greater, res.less, res.equal}));

endmodule

// File: tb/tb_comparator_serial.sv
// Directed bench for comparator_serial: vector table of full-rate comparisons
// plus hand sequences for stalls, mid-run reset and start/valid overlap.
module tb_comparator_serial;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  comparator_serial_if cmp_if ();

  comparator_serial #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmp   (cmp_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       eg;
    logic       el;
    logic       ee;
  } vec_t;

  vec_t vecs[6];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  function automatic logic [2:0] res3();
    return {cmp_if.greater, cmp_if.less, cmp_if.equal};
  endfunction

  // One comparison. stall_len idle beats (with a start pulse inside them) are
  // inserted after stall_at accepted bits; pre_valid drives a (1,0) pair
  // alongside start; start_in_done raises start during the DONE cycle.
  task automatic run_cmp(input string nm, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] exp, input int stall_at, input int stall_len,
                         input bit pre_valid, input bit start_in_done);
    @(negedge clk);
    cmp_if.start = 1'b1; cmp_if.bit_valid = pre_valid;
    cmp_if.a_bit = 1'b1; cmp_if.b_bit = 1'b0;
    @(negedge clk);
    cmp_if.start = 1'b0; cmp_if.bit_valid = 1'b0;
    chk({nm, " busy after start"}, cmp_if.busy, 1);
    chk({nm, " result cleared on start"}, res3(), 3'b000);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (stall_len > 0 && i == WIDTH - 1 - stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          cmp_if.bit_valid = 1'b0; cmp_if.start = 1'b1;
          @(negedge clk);
          cmp_if.start = 1'b0;
          chk({nm, " no done during stall"}, cmp_if.done, 0);
        end
      end
      cmp_if.bit_valid = 1'b1; cmp_if.a_bit = a[i]; cmp_if.b_bit = b[i];
      @(negedge clk);
      if (i > 0) chk({nm, " no early done"}, cmp_if.done, 0);
    end
    cmp_if.bit_valid = 1'b0;
    chk({nm, " done on time"}, cmp_if.done, 1);
    chk({nm, " busy in done"}, cmp_if.busy, 1);
    chk({nm, " result"}, res3(), exp);
    if (start_in_done) cmp_if.start = 1'b1;
    @(negedge clk);
    cmp_if.start = 1'b0;
    chk({nm, " done single pulse"}, cmp_if.done, 0);
    chk({nm, " idle after done"}, cmp_if.busy, 0);
    chk({nm, " result held"}, res3(), exp);
    if (start_in_done) begin
      @(negedge clk);
      chk({nm, " start in done lost"}, cmp_if.busy, 0);
    end
  endtask

  initial begin
    vecs[0] = '{"a5_5a", 8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{"3c_3c", 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"10_11", 8'h10, 8'h11, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{"ff_fe", 8'hFF, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{"7f_80", 8'h7F, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"00_00", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

    cmp_if.start = 1'b0; cmp_if.bit_valid = 1'b0;
    cmp_if.a_bit = 1'b0; cmp_if.b_bit = 1'b0;

    // reset state
    #12;
    chk("reset busy", cmp_if.busy, 0);
    chk("reset done", cmp_if.done, 0);
    chk("reset result", res3(), 3'b000);
    @(negedge clk); rst_n = 1'b1;

    // bit_valid in IDLE must not advance anything
    for (int k = 0; k < 3; k++) begin
      cmp_if.bit_valid = 1'b1; cmp_if.a_bit = 1'b1; cmp_if.b_bit = 1'b0;
      @(negedge clk);
      chk("idle valid busy", cmp_if.busy, 0);
      chk("idle valid result", res3(), 3'b000);
    end
    cmp_if.bit_valid = 1'b0;

    foreach (vecs[v])
      run_cmp(vecs[v].name, vecs[v].a, vecs[v].b, {vecs[v].eg, vecs[v].el, vecs[v].ee},
              0, 0, 1'b0, 1'b0);

    // stalled comparison with start pulses during RUN, then start lost in DONE
    run_cmp("stall_80_7f", 8'h80, 8'h7F, 3'b100, 4, 3, 1'b0, 1'b1);

    // reset after 5 of 8 bits
    @(negedge clk);
    cmp_if.start = 1'b1;
    @(negedge clk);
    cmp_if.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cmp_if.bit_valid = 1'b1; cmp_if.a_bit = 1'b1; cmp_if.b_bit = 1'b0;
      @(negedge clk);
    end
    chk("pre-reset busy", cmp_if.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", cmp_if.busy, 0);
    chk("async reset result", res3(), 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("no done after reset", cmp_if.done, 0);
      chk("idle after reset", cmp_if.busy, 0);
    end
    cmp_if.bit_valid = 1'b0;
    run_cmp("post_reset_00_ff", 8'h00, 8'hFF, 3'b010, 0, 0, 1'b0, 1'b0);

    // start with a (1,0) pair in the same IDLE cycle: that pair is not consumed
    run_cmp("overlap_01_02", 8'h01, 8'h02, 3'b010, 0, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
